fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter FEATURE_WIDTH, default `FEATURE_WIDTH (16), bits per feature element.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default `MEM_DATA_WIDTH (512), AXI read data width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default `MEM_ADDR_WIDTH, AXI address width.
REQ-004 SHALL have port system_clk  in  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port refresh_fetch_addr  in  1  load fetch_addr into read address register.
REQ-007 SHALL have port fetch_addr  in  MEM_ADDR_WIDTH  DDR start byte address.
REQ-008 SHALL have port fetch_req  in  1  single-cycle job start pulse.
REQ-009 SHALL have port fetch_patch_num  in  16  number of 4096-byte bursts in the job.
REQ-010 SHALL have port fetch_finish  out  1  high when no job is active.
REQ-011 SHALL have port fetch_error  out  1  sticky: any non-OKAY rresp in the current job.
REQ-012 SHALL have port fetch_data  out  FEATURE_WIDTH*8  lane to calculate component.
REQ-013 SHALL have port fetch_data_valid  out  1  fetch_data valid.
REQ-014 SHALL have port fetch_data_ready  in  1  consumer accepts fetch_data.
REQ-015 SHALL have ports m00_axi_araddr out MEM_ADDR_WIDTH; m00_axi_arlen out 8 (constant 63); m00_axi_arsize out 3 (constant 3'b110); m00_axi_arburst out 2 (constant INCR); m00_axi_arvalid out 1; m00_axi_arready in 1.
REQ-016 SHALL have ports m00_axi_rdata in MEM_DATA_WIDTH; m00_axi_rresp in 2; m00_axi_rlast in 1; m00_axi_rvalid in 1; m00_axi_rready out 1.

Function
REQ-017 SHALL hold a 256-entry x 512-bit first-word-fall-through FIFO written on R handshakes.
REQ-018 SHALL unpack each FIFO word into four 128-bit lanes, one lane per fetch_data_valid & fetch_data_ready handshake; FIFO pops after the 4th lane.
REQ-019 araddr SHALL load fetch_addr on refresh_fetch_addr; otherwise SHALL add 4096 on each AR handshake; refresh has priority.
REQ-020 FSM states SHALL be IDLE, READ_REQ, READ_DATA, DRAIN, CHECK.
REQ-021 IDLE->READ_REQ when job active, issued burst count < fetch_patch_num, and FIFO occupancy <= 192.
REQ-022 READ_REQ SHALL drive arvalid=1; arvalid SHALL hold until arready; ->READ_DATA on handshake.
REQ-023 READ_DATA SHALL drive rready=1; ->CHECK on rvalid & rlast; CHECK->IDLE after one cycle.
REQ-024 Only one burst SHALL be outstanding at any time.
REQ-025 fetch_req SHALL flush FIFO and unpacker, clear burst counters and fetch_error, and set job active in the same cycle.
REQ-026 fetch_req during READ_DATA SHALL go to DRAIN: rready=1, beats discarded, ->IDLE on rlast; new job proceeds from IDLE.
REQ-027 fetch_req during READ_REQ SHALL keep arvalid asserted; the resulting burst SHALL be drained per REQ-026.
REQ-028 fetch_finish SHALL equal ~fetch_req & (received bursts == fetch_patch_num) & FIFO empty & unpacker empty.
REQ-029 fetch_patch_num = 0 SHALL give fetch_finish high the cycle after fetch_req, with no AR issued.
REQ-030 rresp != 2'b00 on any non-drained beat SHALL set fetch_error; data SHALL still be stored.

Reset
REQ-031 rst_n low SHALL clear araddr, counters, FIFO, unpacker, fetch_error, and job active; SHALL force FSM to IDLE, arvalid=0, rready=0, fetch_data_valid=0, fetch_finish=1.
REQ-032 Reset mid-burst SHALL abandon the burst with no draining; the interconnect is reset alongside.

Configuration
REQ-033 With FETCH_LANE_SWAP_EN defined, lanes SHALL emit rdata[511:384] first, down to [127:0]; without it, [127:0] first, up to [511:384].

Verification
REQ-034 refresh addr 0x1000, fetch_req, patch_num=2 -> AR at 0x1000 then 0x2000, arlen=63, 512 lanes out, fetch_finish high after last lane.
REQ-035 fetch_data_ready held low, patch_num=8 -> exactly 4 bursts issued (occupancy 256); the 5th issues only after occupancy <= 192.
REQ-036 fetch_req at beat 20 of a burst -> remaining 44 beats accepted and discarded; new job's first lane is from its own first beat.
REQ-037 rresp=2'b10 on beat 5 -> fetch_error=1 until next fetch_req; all 256 lanes still delivered.
REQ-038 rdata word = {A,B,C,D} (128-bit each, A high) -> lane order D,C,B,A without FETCH_LANE_SWAP_EN; A,B,C,D with it.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: AXI4 burst reader -> 256x512 FWFT FIFO -> 128-bit lane unpacker.
// Define FETCH_LANE_SWAP_EN to emit the highest lane of each word first.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 16
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module fetch_buffer #(
    parameter int FEATURE_WIDTH  = `FEATURE_WIDTH,
    parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH
) (
    input  logic                       system_clk,
    input  logic                       rst_n,
    input  logic                       refresh_fetch_addr,
    input  logic [MEM_ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                       fetch_req,
    input  logic [15:0]                fetch_patch_num,
    output logic                       fetch_finish,
    output logic                       fetch_error,
    output logic [FEATURE_WIDTH*8-1:0] fetch_data,
    output logic                       fetch_data_valid,
    input  logic                       fetch_data_ready,
    output logic [MEM_ADDR_WIDTH-1:0]  m00_axi_araddr,
    output logic [7:0]                 m00_axi_arlen,
    output logic [2:0]                 m00_axi_arsize,
    output logic [1:0]                 m00_axi_arburst,
    output logic                       m00_axi_arvalid,
    input  logic                       m00_axi_arready,
    input  logic [MEM_DATA_WIDTH-1:0]  m00_axi_rdata,
    input  logic [1:0]                 m00_axi_rresp,
    input  logic                       m00_axi_rlast,
    input  logic                       m00_axi_rvalid,
    output logic                       m00_axi_rready
);

    localparam int LANE_W = FEATURE_WIDTH * 8;
    localparam int LANES  = MEM_DATA_WIDTH / LANE_W;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DEPTH  = 256;
    localparam int PTR_W  = 8;
    localparam int CNT_W  = 9;
    localparam logic [CNT_W-1:0] REFILL_MAX = 9'd192;
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] BURST_BYTES = MEM_ADDR_WIDTH'(4096);

    typedef enum logic [2:0] {
        IDLE,
        READ_REQ,
        READ_DATA,
        DRAIN,
        CHECK
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [15:0]               issued_q, issued_d;
    logic [15:0]               recv_q, recv_d;
    logic                      active_q, active_d;
    logic                      error_q, error_d;
    logic                      drain_pend_q, drain_pend_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [LIDX_W-1:0]         lane_q, lane_d;
    logic [MEM_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [MEM_DATA_WIDTH-1:0] head;
    logic [LIDX_W-1:0]         sel;
    logic                      ar_hs;
    logic                      beat_wr;
    logic                      burst_done;
    logic                      lane_hs;
    logic                      pop;
    logic                      fifo_empty;
    logic                      done;

    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arlen   = 8'd63;
    assign m00_axi_arsize  = 3'b110;
    assign m00_axi_arburst = 2'b01;

    // Beats of a burst issued before the latest fetch_req never reach the FIFO.
    assign ar_hs      = m00_axi_arvalid & m00_axi_arready;
    assign beat_wr    = (state_q == READ_DATA) & m00_axi_rvalid & ~fetch_req;
    assign burst_done = beat_wr & m00_axi_rlast;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    assign fetch_data_valid = ~fifo_empty & ~fetch_req;
    assign lane_hs          = fetch_data_valid & fetch_data_ready;
    assign pop              = lane_hs & (lane_q == LAST_LANE);

    assign done = (recv_q == fetch_patch_num) & fifo_empty & (lane_q == '0);
    assign fetch_finish = ~fetch_req & (~active_q | done);
    assign fetch_error  = error_q;

`ifdef FETCH_LANE_SWAP_EN
    assign sel = LAST_LANE - lane_q;
`else
    assign sel = lane_q;
`endif

    // Select the current 128-bit lane of the FIFO head word.
    always_comb begin
        fetch_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel == LIDX_W'(i)) begin
                fetch_data = head[i*LANE_W +: LANE_W];
            end
        end
    end

    // Burst sequencer: one AR outstanding, stale bursts drained after fetch_req.
    always_comb begin
        state_d         = state_q;
        drain_pend_d    = drain_pend_q;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fetch_req && active_q &&
                    (issued_q < fetch_patch_num) &&
                    (count_q <= REFILL_MAX)) begin
                    state_d = READ_REQ;
                end
            end
            READ_REQ: begin
                m00_axi_arvalid = 1'b1;
                if (fetch_req) begin
                    drain_pend_d = 1'b1;
                end
                if (m00_axi_arready) begin
                    drain_pend_d = 1'b0;
                    state_d = (fetch_req || drain_pend_q) ? DRAIN : READ_DATA;
                end
            end
            READ_DATA: begin
                m00_axi_rready = 1'b1;
                if (m00_axi_rvalid && m00_axi_rlast) begin
                    state_d = fetch_req ? IDLE : CHECK;
                end else if (fetch_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                m00_axi_rready = 1'b1;
                if (m00_axi_rvalid && m00_axi_rlast) begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address, job counters, FIFO pointers and unpacker next-state.
    always_comb begin
        araddr_d = araddr_q;
        if (refresh_fetch_addr) begin
            araddr_d = fetch_addr;
        end else if (ar_hs) begin
            araddr_d = araddr_q + BURST_BYTES;
        end
        if (fetch_req) begin
            issued_d = '0;
            recv_d   = '0;
            error_d  = 1'b0;
            active_d = 1'b1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            lane_d   = '0;
        end else begin
            issued_d = issued_q + 16'(ar_hs & ~drain_pend_q);
            recv_d   = recv_q + 16'(burst_done);
            error_d  = error_q | (beat_wr & (m00_axi_rresp != 2'b00));
            active_d = active_q & ~done;
            wr_ptr_d = wr_ptr_q + PTR_W'(beat_wr);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(beat_wr) - CNT_W'(pop);
            lane_d   = lane_q;
            if (lane_hs) begin
                lane_d = pop ? '0 : lane_q + 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            issued_q     <= '0;
            recv_q       <= '0;
            active_q     <= 1'b0;
            error_q      <= 1'b0;
            drain_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lane_q       <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            issued_q     <= issued_d;
            recv_q       <= recv_d;
            active_q     <= active_d;
            error_q      <= error_d;
            drain_pend_q <= drain_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lane_q       <= lane_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers and count only.
    always_ff @(posedge system_clk) begin
        if (beat_wr) begin
            mem_q[wr_ptr_q] <= m00_axi_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: job table plus random jobs against a lane-stream model.
// Honours FETCH_LANE_SWAP_EN for the expected lane order.
`timescale 1ns/1ps

module tb_fetch_buffer;

`ifdef FETCH_LANE_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic         system_clk = 1'b0;
    logic         rst_n;
    logic         refresh_fetch_addr;
    logic [31:0]  fetch_addr;
    logic         fetch_req;
    logic [15:0]  fetch_patch_num;
    logic         fetch_finish;
    logic         fetch_error;
    logic [127:0] fetch_data;
    logic         fetch_data_valid;
    logic         fetch_data_ready;
    logic [31:0]  m00_axi_araddr;
    logic [7:0]   m00_axi_arlen;
    logic [2:0]   m00_axi_arsize;
    logic [1:0]   m00_axi_arburst;
    logic         m00_axi_arvalid;
    logic         m00_axi_arready;
    logic [511:0] m00_axi_rdata;
    logic [1:0]   m00_axi_rresp;
    logic         m00_axi_rlast;
    logic         m00_axi_rvalid;
    logic         m00_axi_rready;

    fetch_buffer #(
        .FEATURE_WIDTH(16),
        .MEM_DATA_WIDTH(512),
        .MEM_ADDR_WIDTH(32)
    ) dut (
        .system_clk(system_clk),
        .rst_n(rst_n),
        .refresh_fetch_addr(refresh_fetch_addr),
        .fetch_addr(fetch_addr),
        .fetch_req(fetch_req),
        .fetch_patch_num(fetch_patch_num),
        .fetch_finish(fetch_finish),
        .fetch_error(fetch_error),
        .fetch_data(fetch_data),
        .fetch_data_valid(fetch_data_valid),
        .fetch_data_ready(fetch_data_ready),
        .m00_axi_araddr(m00_axi_araddr),
        .m00_axi_arlen(m00_axi_arlen),
        .m00_axi_arsize(m00_axi_arsize),
        .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata(m00_axi_rdata),
        .m00_axi_rresp(m00_axi_rresp),
        .m00_axi_rlast(m00_axi_rlast),
        .m00_axi_rvalid(m00_axi_rvalid),
        .m00_axi_rready(m00_axi_rready)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [31:0] addr;
        int          patch;
        int          err_beat;
        logic        exp_err;
        int          exp_lanes;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    int           ar_count = 0;
    int           job_beats = 0;
    int           lanes_seen = 0;
    int           cur_tag = 0;
    int           err_beat = -1;
    logic [31:0]  job_addr = '0;
    bit           burst_active = 1'b0;
    logic [31:0]  b_addr = '0;
    int           b_tag = 0;
    int           b_beat = 0;
    int           credits = 0;
    bit           ready_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] lane_pat(logic [31:0] a, int beat, int j, int tag);
        return {16'hC0DE, 8'(tag), 8'(j), a, 32'(beat), ~a};
    endfunction

    function automatic logic [511:0] beat_word(logic [31:0] a, int beat, int tag);
        logic [511:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w[128*j +: 128] = lane_pat(a, beat, j, tag);
        end
        return w;
    endfunction

    // AXI read slave and lane consumer; decides handshakes on the falling edge.
    initial begin : bus
        bit ar_fire;
        bit r_fire;
        bit d_fire;
        forever begin
            @(negedge system_clk);
            if (!rst_n) begin
                burst_active = 1'b0;
                continue;
            end
            ar_fire = m00_axi_arvalid && m00_axi_arready;
            r_fire  = m00_axi_rvalid && m00_axi_rready;
            d_fire  = fetch_data_valid && fetch_data_ready;
            if (d_fire) begin
                lanes_seen++;
                if (credits > 0) credits--;
                if (exp_q.size() != 0) begin
                    chk("lane_data", fetch_data, exp_q.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL lane_extra actual=%0h required=none", fetch_data);
                end
            end
            if (r_fire) begin
                if (b_tag == cur_tag) job_beats++;
                b_beat++;
                if (b_beat == 64) burst_active = 1'b0;
            end
            if (ar_fire) begin
                chk("ar_single", 128'(burst_active), 0);
                chk("ar_addr", m00_axi_araddr, job_addr + 32'(ar_count) * 32'd4096);
                chk("ar_len", m00_axi_arlen, 63);
                chk("ar_size", m00_axi_arsize, 3'b110);
                chk("ar_burst", m00_axi_arburst, 2'b01);
                burst_active = 1'b1;
                b_addr = m00_axi_araddr;
                b_tag = cur_tag;
                b_beat = 0;
                ar_count++;
            end
            @(posedge system_clk);
            #1;
            m00_axi_arready = 1'($urandom_range(0, 1));
            if (r_fire || !m00_axi_rvalid) begin
                if (burst_active && ($urandom_range(0, 3) != 0)) begin
                    m00_axi_rvalid = 1'b1;
                    m00_axi_rdata  = beat_word(b_addr, b_beat, b_tag);
                    m00_axi_rlast  = (b_beat == 63);
                    m00_axi_rresp  = (b_tag == cur_tag && job_beats == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    m00_axi_rvalid = 1'b0;
                    m00_axi_rlast  = 1'b0;
                    m00_axi_rresp  = 2'b00;
                end
            end
            fetch_data_ready = ready_mode ? (credits > 0) : 1'($urandom_range(0, 1));
        end
    end

    task automatic start_job(input logic [31:0] addr, input int patch, input int tag, input int eb);
        @(posedge system_clk);
        #1;
        refresh_fetch_addr = 1'b1;
        fetch_addr = addr;
        @(posedge system_clk);
        #1;
        refresh_fetch_addr = 1'b0;
        fetch_req = 1'b1;
        fetch_patch_num = 16'(patch);
        cur_tag = tag;
        job_addr = addr;
        err_beat = eb;
        ar_count = 0;
        job_beats = 0;
        lanes_seen = 0;
        exp_q.delete();
        for (int b = 0; b < patch; b++)
            for (int beat = 0; beat < 64; beat++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(lane_pat(addr + 32'(b) * 32'd4096, beat, SWAP ? 3 - k : k, tag));
        @(negedge system_clk);
        chk("finish_during_req", 128'(fetch_finish), 0);
        @(posedge system_clk);
        #1;
        fetch_req = 1'b0;
        @(negedge system_clk);
        chk("error_cleared", 128'(fetch_error), 0);
    endtask

    task automatic wait_done(input int patch, input logic eexp);
        int n = 0;
        int lim = 2000 * patch + 500;
        while (!(exp_q.size() == 0 && fetch_finish === 1'b1) && n < lim) begin
            @(negedge system_clk);
            n++;
        end
        chk("job_done", 128'(n < lim), 1);
        chk("lanes", lanes_seen, patch * 256);
        chk("ar_count", ar_count, patch);
        chk("beats", job_beats, patch * 64);
        chk("error", 128'(fetch_error), 128'(eexp));
        chk("no_outstanding", 128'(burst_active), 0);
    endtask

    initial begin : main
        vec_t vecs[5];
        int   n;
        vecs[0] = '{32'h0000_1000, 2, -1, 1'b0, 512};
        vecs[1] = '{32'h0004_0000, 1, 5, 1'b1, 256};
        vecs[2] = '{32'h0010_0000, 3, -1, 1'b0, 768};
        vecs[3] = '{32'h8000_0040, 1, 63, 1'b1, 256};
        vecs[4] = '{32'h0002_0000, 0, -1, 1'b0, 0};

        rst_n = 1'b0;
        refresh_fetch_addr = 1'b0;
        fetch_addr = '0;
        fetch_req = 1'b0;
        fetch_patch_num = 16'd5;
        fetch_data_ready = 1'b0;
        m00_axi_arready = 1'b0;
        m00_axi_rdata = '0;
        m00_axi_rresp = 2'b00;
        m00_axi_rlast = 1'b0;
        m00_axi_rvalid = 1'b0;

        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        chk("rst_arvalid", 128'(m00_axi_arvalid), 0);
        chk("rst_rready", 128'(m00_axi_rready), 0);
        chk("rst_valid", 128'(fetch_data_valid), 0);
        chk("rst_finish", 128'(fetch_finish), 1);
        chk("rst_error", 128'(fetch_error), 0);
        chk("rst_araddr", m00_axi_araddr, 0);
        @(posedge system_clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            start_job(vecs[i].addr, vecs[i].patch, 1 + i, vecs[i].err_beat);
            wait_done(vecs[i].patch, vecs[i].exp_err);
            chk("vec_lanes", lanes_seen, vecs[i].exp_lanes);
        end

        start_job(32'h0000_7000, 0, 20, -1);
        chk("zero_finish", 128'(fetch_finish), 1);
        repeat (30) @(negedge system_clk);
        chk("zero_no_ar", ar_count, 0);
        chk("zero_finish_hold", 128'(fetch_finish), 1);

        ready_mode = 1'b1;
        credits = 0;
        start_job(32'h0100_0000, 8, 30, -1);
        n = 0;
        while (!(ar_count == 4 && !burst_active) && n < 3000) begin
            @(negedge system_clk);
            n++;
        end
        chk("bp_four_reached", 128'(n < 3000), 1);
        repeat (300) @(negedge system_clk);
        chk("bp_stall_256", ar_count, 4);
        chk("bp_valid", 128'(fetch_data_valid), 1);
        credits = 252;
        n = 0;
        while (credits != 0 && n < 2000) begin
            @(negedge system_clk);
            n++;
        end
        chk("bp_credits_used", 128'(n < 2000), 1);
        repeat (300) @(negedge system_clk);
        chk("bp_stall_193", ar_count, 4);
        credits = 4;
        n = 0;
        while (ar_count != 5 && n < 300) begin
            @(negedge system_clk);
            n++;
        end
        chk("bp_fifth_at_192", ar_count, 5);
        ready_mode = 1'b0;
        wait_done(8, 1'b0);

        start_job(32'h0030_0000, 2, 40, -1);
        n = 0;
        while (!(burst_active && b_tag == 40 && b_beat >= 20) && n < 2000) begin
            @(negedge system_clk);
            n++;
        end
        chk("flush_beat20", 128'(n < 2000), 1);
        chk("flush_a_ar", ar_count, 1);
        start_job(32'h0050_0000, 1, 41, -1);
        wait_done(1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            logic [31:0] a;
            int p;
            int eb;
            a = $urandom;
            p = $urandom_range(1, 3);
            eb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, p * 64 - 1)) : -1;
            start_job(a, p, 50 + r, eb);
            wait_done(p, eb >= 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
